// File: rtl/mem_arb_pkg.sv
// Shared types for the imem/dmem single-port memory arbiter.
package mem_arb_pkg;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_MASK_W = ARB_DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} arb_state_t;
    typedef enum logic {PORT_I, PORT_D} arb_port_t;

    typedef struct packed {
        logic                  valid;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_MASK_W-1:0] rmask;
        logic [ARB_MASK_W-1:0] wmask;
        logic [ARB_DATA_W-1:0] wdata;
    } req_slot_t;
endpackage

// File: rtl/arb_req_slot.sv
// One pending-request register: captures a mask pulse, holds it until its response, flags overlaps.
module arb_req_slot
    import mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ARB_ADDR_W-1:0] addr,
    input  logic [ARB_MASK_W-1:0] rmask,
    input  logic [ARB_MASK_W-1:0] wmask,
    input  logic [ARB_DATA_W-1:0] wdata,
    input  logic                  clear,
    output req_slot_t             slot,
    output logic                  overlap
);
    logic                  valid_q;
    logic [ARB_ADDR_W-1:0] addr_q;
    logic [ARB_MASK_W-1:0] rmask_q;
    logic [ARB_MASK_W-1:0] wmask_q;
    logic [ARB_DATA_W-1:0] wdata_q;
    logic                  pulse;
    logic                  load;

    // A pulse coinciding with this slot's own response reuses the slot in the same edge.
    assign pulse   = (|rmask) | (|wmask);
    assign load    = pulse && (!valid_q || clear);
    assign overlap = pulse && valid_q && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end else if (clear) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            addr_q  <= addr;
            rmask_q <= rmask;
            wmask_q <= wmask;
            wdata_q <= wdata;
        end
    end

    assign slot = '{valid: valid_q, addr: addr_q, rmask: rmask_q, wmask: wmask_q, wdata: wdata_q};
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the CPU imem and dmem ports.
// D has priority; I is forced after STARVE_LIMIT consecutive D grants while it waits.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = ARB_ADDR_W,
    parameter int DATA_WIDTH   = ARB_DATA_W,
    parameter int MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [MASK_WIDTH-1:0] imem_rmask,
    output logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  imem_resp,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [MASK_WIDTH-1:0] dmem_rmask,
    input  logic [MASK_WIDTH-1:0] dmem_wmask,
    input  logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  dmem_resp,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [MASK_WIDTH-1:0] mem_rmask,
    output logic [MASK_WIDTH-1:0] mem_wmask,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic [1:0]            err
);
    localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    arb_port_t        owner_q, pick;
    req_slot_t        slot_i, slot_d, cur;
    logic             ovl_i, ovl_d;
    logic             any_full, grant, resp_ok, clr_i, clr_d;
    logic [CNT_W-1:0] starve_q;
    logic [1:0]       err_q;

    assign any_full = slot_i.valid | slot_d.valid;
    assign grant    = (state_q == IDLE) && any_full;
    assign resp_ok  = (state_q == BUSY) && mem_resp;
    assign clr_i    = resp_ok && (owner_q == PORT_I);
    assign clr_d    = resp_ok && (owner_q == PORT_D);

    arb_req_slot u_slot_i (
        .clk     (clk),
        .rst     (rst),
        .addr    (imem_addr),
        .rmask   (imem_rmask),
        .wmask   ('0),
        .wdata   ('0),
        .clear   (clr_i),
        .slot    (slot_i),
        .overlap (ovl_i)
    );

    arb_req_slot u_slot_d (
        .clk     (clk),
        .rst     (rst),
        .addr    (dmem_addr),
        .rmask   (dmem_rmask),
        .wmask   (dmem_wmask),
        .wdata   (dmem_wdata),
        .clear   (clr_d),
        .slot    (slot_d),
        .overlap (ovl_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= PORT_I;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= pick;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pick    = PORT_D;
        if (slot_i.valid && (!slot_d.valid || (starve_q == LIMIT))) begin
            pick = PORT_I;
        end
        case (state_q)
            IDLE:    if (any_full) state_d = ISSUE;
            ISSUE:   state_d = BUSY;
            BUSY:    if (mem_resp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counts D grants taken while I is waiting; any I grant or an empty I slot restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (grant && (pick == PORT_I)) begin
            starve_q <= '0;
        end else if (grant && slot_i.valid) begin
            if (starve_q != LIMIT) begin
                starve_q <= starve_q + CNT_W'(1);
            end
        end else if (!slot_i.valid) begin
            starve_q <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q[0] <= err_q[0] | ovl_i | ovl_d;
            err_q[1] <= err_q[1] | (mem_resp && (state_q != BUSY));
        end
    end

    assign cur = (owner_q == PORT_D) ? slot_d : slot_i;
    assign err = err_q;

    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_rmask  = '0;
        mem_wmask  = '0;
        imem_resp  = 1'b0;
        imem_rdata = '0;
        dmem_resp  = 1'b0;
        dmem_rdata = '0;
        if (state_q != IDLE) begin
            mem_addr  = cur.addr;
            mem_wdata = cur.wdata;
        end
        if (state_q == ISSUE) begin
            mem_rmask = cur.rmask;
            mem_wmask = cur.wmask;
        end
        if (clr_i) begin
            imem_resp  = 1'b1;
            imem_rdata = mem_rdata;
        end
        if (clr_d) begin
            dmem_resp  = 1'b1;
            dmem_rdata = mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-vector table plus starvation, error and reset sequences.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr = '0;
    logic [3:0]  imem_rmask = '0;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr = '0;
    logic [3:0]  dmem_rmask = '0;
    logic [3:0]  dmem_wmask = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic [1:0]  err;

    int total = 0;
    int bad = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_addr   (mem_addr),
        .mem_rmask  (mem_rmask),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  irm;
        logic [31:0] ia;
        logic [3:0]  drm;
        logic [3:0]  dwm;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        mr;
        logic [31:0] mrd;
        logic [3:0]  e_rm;
        logic [3:0]  e_wm;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_ir;
        logic [31:0] e_ird;
        logic        e_dr;
        logic [31:0] e_drd;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic [3:0] irm, input logic [31:0] ia,
                                input logic [3:0] drm, input logic [3:0] dwm,
                                input logic [31:0] da, input logic [31:0] dwd,
                                input logic mr, input logic [31:0] mrd,
                                input logic [3:0] e_rm, input logic [3:0] e_wm,
                                input logic [31:0] e_addr, input logic [31:0] e_wd,
                                input logic e_ir, input logic [31:0] e_ird,
                                input logic e_dr, input logic [31:0] e_drd);
        vec_t v;
        v.irm = irm; v.ia = ia; v.drm = drm; v.dwm = dwm; v.da = da; v.dwd = dwd;
        v.mr = mr; v.mrd = mrd; v.e_rm = e_rm; v.e_wm = e_wm; v.e_addr = e_addr;
        v.e_wd = e_wd; v.e_ir = e_ir; v.e_ird = e_ird; v.e_dr = e_dr; v.e_drd = e_drd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Advance to just after the next rising edge and drop all one-cycle pulses.
    task automatic next_cycle;
        @(posedge clk);
        #1;
        imem_rmask = '0;
        dmem_rmask = '0;
        dmem_wmask = '0;
        mem_resp   = 1'b0;
    endtask

    task automatic wait_issue(output logic found);
        found = 1'b0;
        for (int t = 0; t < 8 && !found; t++) begin
            next_cycle();
            @(negedge clk);
            if (mem_rmask != 0 || mem_wmask != 0) found = 1'b1;
        end
    endtask

    logic found;
    logic seen;
    logic is_i;

    initial begin
        tbl[0]  = mk(4'hF, 32'h6000_0000, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                         4'hF, 0, 32'h6000_0000, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 32'h6000_0000, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h13,                    0, 0, 32'h6000_0000, 0, 1, 32'h13, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 4'h3, 32'h100, 32'hBEEF, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                         0, 4'h3, 32'h100, 32'hBEEF, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 32'h100, 32'hBEEF, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 32'hDEAD,                  0, 0, 32'h100, 32'hBEEF, 0, 0, 1, 32'hDEAD);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(4'hF, 32'hA0, 4'hF, 0, 32'hB0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,                         4'hF, 0, 32'hB0, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 32'hB0, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 32'h22,                    0, 0, 32'hB0, 0, 0, 0, 1, 32'h22);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,                         4'hF, 0, 32'hA0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 32'hA0, 0, 0, 0, 0, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 1, 32'h11,                    0, 0, 32'hA0, 0, 1, 32'h11, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_mem", {mem_rmask, mem_wmask, mem_addr, mem_wdata}, '0);
        chk("reset_up", {imem_resp, imem_rdata, dmem_resp, dmem_rdata, err}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table: I-only fetch, store, contention
        for (int i = 0; i < 22; i++) begin
            next_cycle();
            imem_rmask = tbl[i].irm;  imem_addr  = tbl[i].ia;
            dmem_rmask = tbl[i].drm;  dmem_wmask = tbl[i].dwm;
            dmem_addr  = tbl[i].da;   dmem_wdata = tbl[i].dwd;
            mem_resp   = tbl[i].mr;   mem_rdata  = tbl[i].mrd;
            @(negedge clk);
            chk($sformatf("vec%0d_mem", i), {mem_rmask, mem_wmask, mem_addr, mem_wdata},
                {tbl[i].e_rm, tbl[i].e_wm, tbl[i].e_addr, tbl[i].e_wd});
            chk($sformatf("vec%0d_up", i), {imem_resp, imem_rdata, dmem_resp, dmem_rdata, err},
                {tbl[i].e_ir, tbl[i].e_ird, tbl[i].e_dr, tbl[i].e_drd, 2'b00});
        end

        // Starvation: expected grant order D D D D I D D D D I D
        next_cycle();
        imem_rmask = 4'hF; imem_addr = 32'h100;
        dmem_rmask = 4'hF; dmem_addr = 32'hD00;
        for (int g = 0; g < 11; g++) begin
            is_i = (g == 4 || g == 9);
            wait_issue(found);
            chk($sformatf("starve%0d_issue", g), {79'd0, found}, 80'd1);
            chk($sformatf("starve%0d_addr", g), {48'd0, mem_addr}, is_i ? 80'h100 : 80'hD00);
            next_cycle();
            next_cycle();
            mem_resp  = 1'b1;
            mem_rdata = 32'h40 + 32'(g);
            if (!is_i && g != 10) dmem_rmask = 4'hF;
            if (g == 4) imem_rmask = 4'hF;
            @(negedge clk);
            if (is_i)
                chk($sformatf("starve%0d_resp", g), {46'd0, imem_resp, imem_rdata, dmem_resp},
                    {46'd0, 1'b1, 32'h40 + 32'(g), 1'b0});
            else
                chk($sformatf("starve%0d_resp", g), {46'd0, dmem_resp, dmem_rdata, imem_resp},
                    {46'd0, 1'b1, 32'h40 + 32'(g), 1'b0});
        end

        // Overlapping imem pulse while its fetch is in flight
        next_cycle();
        imem_rmask = 4'hF; imem_addr = 32'h200;
        wait_issue(found);
        chk("ovl_issue", {48'd0, mem_addr}, 80'h200);
        next_cycle();
        imem_rmask = 4'hF; imem_addr = 32'h300;
        next_cycle();
        @(negedge clk);
        chk("ovl_err", {78'd0, err}, 80'd1);
        next_cycle();
        mem_resp = 1'b1; mem_rdata = 32'h99;
        @(negedge clk);
        chk("ovl_resp", {47'd0, imem_resp, imem_rdata}, {47'd0, 1'b1, 32'h99});
        seen = 1'b0;
        for (int t = 0; t < 4; t++) begin
            next_cycle();
            @(negedge clk);
            if (mem_rmask != 0 || mem_wmask != 0) seen = 1'b1;
        end
        chk("ovl_dropped", {79'd0, seen}, 80'd0);

        // Stray mem_resp while idle
        next_cycle();
        mem_resp = 1'b1; mem_rdata = 32'h77;
        @(negedge clk);
        chk("idle_resp_fwd", {78'd0, imem_resp, dmem_resp}, 80'd0);
        next_cycle();
        @(negedge clk);
        chk("idle_resp_err", {78'd0, err}, 80'd3);

        // Asynchronous reset in the middle of a BUSY load
        next_cycle();
        dmem_rmask = 4'hF; dmem_addr = 32'h400;
        wait_issue(found);
        chk("rst_issue", {48'd0, mem_addr}, 80'h400);
        next_cycle();
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async", {mem_rmask, mem_wmask, mem_addr, mem_wdata}, '0);
        chk("rst_async_err", {78'd0, err}, 80'd0);
        next_cycle();
        rst = 1'b0;
        mem_resp = 1'b1; mem_rdata = 32'h66;
        @(negedge clk);
        chk("late_resp_fwd", {78'd0, imem_resp, dmem_resp}, 80'd0);
        next_cycle();
        @(negedge clk);
        chk("late_resp_err", {78'd0, err}, 80'd2);
        next_cycle();
        dmem_rmask = 4'hF; dmem_addr = 32'h500;
        wait_issue(found);
        chk("post_rst_issue", {47'd0, found, mem_addr}, {47'd0, 1'b1, 32'h500});
        next_cycle();
        next_cycle();
        mem_resp = 1'b1; mem_rdata = 32'h55;
        @(negedge clk);
        chk("post_rst_resp", {47'd0, dmem_resp, dmem_rdata}, {47'd0, 1'b1, 32'h55});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
